// File: rtl/req_pending_latch.sv
// req_pending_latch: captures request events into per-bit pending flags cleared by indexed ack, with enable mask and sticky overflow
// Optional rising-edge event detection is built when REQ_PENDING_EDGE_DETECT_EN is defined; otherwise request levels are events.
module req_pending_latch #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter logic [WIDTH-1:0] MASK_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_data,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] pending_raw,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] overflow,
  output logic             any
);
  logic [WIDTH-1:0] raw_q, mask_q, ovf_q, ev, clr, ev_ovf;
`ifdef REQ_PENDING_EDGE_DETECT_EN
  logic [WIDTH-1:0] req_q;
  // previous request sample; zero after reset so a held request counts as an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) req_q <= '0;
    else req_q <= req;
  assign ev = req & ~req_q;
`else
  assign ev = req;
`endif
  // one-hot clear; indices at or above WIDTH shift the bit out and clear nothing
  always_comb begin
    clr = ack ? (WIDTH'(1) << ack_idx) : '0;
    ev_ovf = ev & raw_q & ~clr;
  end
  // pending, overflow and mask state; a new event wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      raw_q <= '0;
      ovf_q <= '0;
      mask_q <= MASK_RST;
    end else begin
      raw_q <= (raw_q & ~clr) | ev;
      ovf_q <= ovf_clr ? ev_ovf : (ovf_q | ev_ovf);
      if (mask_wr) mask_q <= mask_data;
    end
  assign pending = raw_q & mask_q;
  assign pending_raw = raw_q;
  assign mask = mask_q;
  assign overflow = ovf_q;
  assign any = |pending;
endmodule

// File: tb/tb_req_pending_latch.sv
// tb_req_pending_latch: directed self-checking bench for req_pending_latch
module tb_req_pending_latch;
  logic clk = 0, rst = 1, mask_wr = 0, ack = 0, ovf_clr = 0;
  logic [7:0] req = 0, mask_data = 0;
  logic [2:0] ack_idx = 0;
  logic [7:0] pending, pending_raw, mask, overflow;
  logic any;
  int n_checks = 0, n_fail = 0;

  req_pending_latch dut (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_data(mask_data),
    .ack(ack), .ack_idx(ack_idx), .ovf_clr(ovf_clr), .pending(pending),
    .pending_raw(pending_raw), .mask(mask), .overflow(overflow), .any(any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst = 1; req = 0; mask_wr = 0; mask_data = 0; ack = 0; ack_idx = 0; ovf_clr = 0;
    #3;
    tick;
    rst = 0;
  endtask

  task test_reset;
    do_reset;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL rst_init pending got=%h exp=00", pending); end
    n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL rst_init mask got=%h exp=FF", mask); end
    n_checks++; if (overflow !== 8'h00 || any !== 1'b0) begin n_fail++; $display("FAIL rst_init ovf/any got=%h/%b exp=00/0", overflow, any); end
    mask_wr = 1; mask_data = 8'h0F; req = 8'hA5; tick;
    mask_wr = 0; req = 0; tick;
    req = 8'hA5; tick;
    req = 0;
    n_checks++; if (pending_raw !== 8'hA5 || overflow !== 8'hA5) begin n_fail++; $display("FAIL rst_pre raw/ovf got=%h/%h exp=A5/A5", pending_raw, overflow); end
    #2; rst = 1; #1;
    n_checks++; if (pending !== 8'h00 || pending_raw !== 8'h00) begin n_fail++; $display("FAIL rst_async pending/raw got=%h/%h exp=00/00", pending, pending_raw); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL rst_async overflow got=%h exp=00", overflow); end
    n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL rst_async mask got=%h exp=FF", mask); end
    tick; rst = 0;
  endtask

  task test_capture_ack;
    do_reset;
    req = 8'h90; tick; req = 0;
    n_checks++; if (pending !== 8'h90 || any !== 1'b1) begin n_fail++; $display("FAIL cap pending/any got=%h/%b exp=90/1", pending, any); end
    ack = 1; ack_idx = 7; tick;
    n_checks++; if (pending !== 8'h10 || any !== 1'b1) begin n_fail++; $display("FAIL ack7 pending/any got=%h/%b exp=10/1", pending, any); end
    ack_idx = 4; tick;
    n_checks++; if (pending !== 8'h00 || any !== 1'b0) begin n_fail++; $display("FAIL ack4 pending/any got=%h/%b exp=00/0", pending, any); end
    ack = 0; req = 8'h01; tick; req = 0;
    ack = 1; ack_idx = 5; tick; ack = 0;
    n_checks++; if (pending !== 8'h01) begin n_fail++; $display("FAIL ack_nonpending pending got=%h exp=01", pending); end
  endtask

  task test_mask;
    do_reset;
    mask_wr = 1; mask_data = 8'h0F; tick; mask_wr = 0;
    n_checks++; if (mask !== 8'h0F) begin n_fail++; $display("FAIL mask_wr mask got=%h exp=0F", mask); end
    req = 8'h30; tick; req = 0;
    n_checks++; if (pending !== 8'h00 || pending_raw !== 8'h30 || any !== 1'b0) begin n_fail++; $display("FAIL masked pending/raw/any got=%h/%h/%b exp=00/30/0", pending, pending_raw, any); end
    mask_wr = 1; mask_data = 8'hFF; tick; mask_wr = 0;
    n_checks++; if (pending !== 8'h30 || any !== 1'b1) begin n_fail++; $display("FAIL unmask pending/any got=%h/%b exp=30/1", pending, any); end
  endtask

  task test_set_vs_clear;
    do_reset;
    req = 8'h04; tick; req = 0; tick;
    req = 8'h04; ack = 1; ack_idx = 2; tick; req = 0; ack = 0;
    n_checks++; if (pending !== 8'h04) begin n_fail++; $display("FAIL setclr pending got=%h exp=04", pending); end
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL setclr overflow got=%h exp=00", overflow); end
  endtask

  task test_overflow;
    do_reset;
    req = 8'h02; tick; req = 0; tick;
    req = 8'h02; tick; req = 0;
    n_checks++; if (overflow !== 8'h02 || pending !== 8'h02) begin n_fail++; $display("FAIL ovf set ovf/pending got=%h/%h exp=02/02", overflow, pending); end
    ovf_clr = 1; tick; ovf_clr = 0;
    n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL ovf_clr overflow got=%h exp=00", overflow); end
    req = 8'h02; ovf_clr = 1; tick; req = 0; ovf_clr = 0;
    n_checks++; if (overflow !== 8'h02) begin n_fail++; $display("FAIL ovf_clr_vs_event overflow got=%h exp=02", overflow); end
  endtask

  task test_held;
    do_reset;
    req = 8'h01; tick;
    n_checks++; if (pending !== 8'h01 || overflow !== 8'h00) begin n_fail++; $display("FAIL held c1 pending/ovf got=%h/%h exp=01/00", pending, overflow); end
`ifdef REQ_PENDING_EDGE_DETECT_EN
    tick;
    n_checks++; if (pending !== 8'h01 || overflow !== 8'h00) begin n_fail++; $display("FAIL held c2 pending/ovf got=%h/%h exp=01/00", pending, overflow); end
    ack = 1; ack_idx = 0; tick; ack = 0;
    n_checks++; if (pending !== 8'h00) begin n_fail++; $display("FAIL held ack pending got=%h exp=00", pending); end
    tick;
    n_checks++; if (pending !== 8'h00 || overflow !== 8'h00) begin n_fail++; $display("FAIL held stays pending/ovf got=%h/%h exp=00/00", pending, overflow); end
    req = 0; tick; req = 8'h01; tick;
    n_checks++; if (pending !== 8'h01) begin n_fail++; $display("FAIL held re-edge pending got=%h exp=01", pending); end
`else
    tick;
    n_checks++; if (pending !== 8'h01 || overflow !== 8'h01) begin n_fail++; $display("FAIL held c2 pending/ovf got=%h/%h exp=01/01", pending, overflow); end
    tick;
    n_checks++; if (pending !== 8'h01 || overflow !== 8'h01) begin n_fail++; $display("FAIL held c3 pending/ovf got=%h/%h exp=01/01", pending, overflow); end
    ack = 1; ack_idx = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (pending !== 8'h01) begin n_fail++; $display("FAIL held ack c%0d pending got=%h exp=01", k, pending); end
    end
    ack = 0;
`endif
    req = 0;
  endtask

  initial begin
    test_reset;
    test_capture_ack;
    test_mask;
    test_set_vs_clear;
    test_overflow;
    test_held;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
